// File: rtl/ref_clk_supervisor_pkg.sv
// Shared definitions for the reference-clock supervisor: FSM state encoding
// and the timing-mux select values.
package ref_clk_supervisor_pkg;

   // State encoding is visible on state_o, so the values are fixed.
   typedef enum logic [1:0] {
      ST_INIT = 2'b00,
      ST_PRI  = 2'b01,
      ST_SEC  = 2'b10,
      ST_HOLD = 2'b11
   } state_t;

   // Timing mux select: f5 path or f64 path.
   localparam logic SEL_F5  = 1'b0;
   localparam logic SEL_F64 = 1'b1;

endpackage

// File: rtl/ref_clk_supervisor_err_debounce.sv
// Debounce filter for one raw monitor error flag. The filtered flag only
// follows the raw flag after the raw value has differed from it for
// DEB_CYCLES consecutive clocks; shorter glitches are discarded.
module err_debounce #(
   parameter int DEB_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_in,
   output logic filt_out
);

   localparam int            CW       = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic          r_filt;

   // Mismatch run counter and filtered flag; the flag starts as "bad".
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_filt <= 1'b1;
      end else if (raw_in == r_filt) begin
         r_cnt  <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_filt <= raw_in;
         r_cnt  <= '0;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   assign filt_out = r_filt;

endmodule

// File: rtl/ref_clk_supervisor.sv
// Reference-clock supervisor: debounces the f5/f64 monitor error flags and
// selects the timing source (primary f5, secondary f64, or holdover), with an
// optional revertive return to f5 and a manual force override.
module ref_clk_supervisor
   import ref_clk_supervisor_pkg::*;
#(
   parameter int DEB_CYCLES = 1024,
   parameter int REVERT_DLY = 16384,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             err_5,
   input  logic             err_64,
   input  logic             force_en,
   input  logic             force_sel,
   input  logic             revertive,
   output logic             sel_f64,
   output logic             src_valid,
   output logic             holdover,
   output logic             switch_pulse,
   output logic [CNT_W-1:0] switch_cnt,
   output logic [1:0]       state_o
);

   localparam int               RW      = $clog2(REVERT_DLY);
   localparam logic [RW-1:0]    REV_MAX = RW'(REVERT_DLY - 1);
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   logic             w_filt_5;
   logic             w_filt_64;
   logic             w_good_5;
   logic             w_good_64;
   logic             w_rev_en;
   logic             w_sel_nxt;
   logic             w_sel_change;
   state_t           w_state_nxt;

   state_t           r_state;
   logic             r_sel;
   logic             r_src_valid;
   logic             r_holdover;
   logic             r_pulse;
   logic [CNT_W-1:0] r_cnt;
   logic [RW-1:0]    r_rev_cnt;

   err_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_5 (
      .clk      (clk),
      .rst      (rst),
      .raw_in   (err_5),
      .filt_out (w_filt_5)
   );

   err_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_64 (
      .clk      (clk),
      .rst      (rst),
      .raw_in   (err_64),
      .filt_out (w_filt_64)
   );

   // Filtered flags are registers, so the FSM sees them one cycle after they settle.
   assign w_good_5  = ~w_filt_5;
   assign w_good_64 = ~w_filt_64;

   // Revert timer runs only while parked on f64 with f5 healthy and revert enabled.
   assign w_rev_en  = (r_state == ST_SEC) & w_good_5 & revertive & ~force_en;

   // Next-state selection: force first, then the automatic source rules.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      if (force_en) begin
         if (force_sel == SEL_F64) w_state_nxt = w_good_64 ? ST_SEC : ST_HOLD;
         else                      w_state_nxt = w_good_5  ? ST_PRI : ST_HOLD;
      end else begin
         case (r_state)
            ST_INIT, ST_HOLD: begin
               if      (w_good_5)  w_state_nxt = ST_PRI;
               else if (w_good_64) w_state_nxt = ST_SEC;
            end
            ST_PRI: begin
               if (!w_good_5) w_state_nxt = w_good_64 ? ST_SEC : ST_HOLD;
            end
            ST_SEC: begin
               if (!w_good_64)                           w_state_nxt = w_good_5 ? ST_PRI : ST_HOLD;
               else if (w_rev_en && r_rev_cnt == REV_MAX) w_state_nxt = ST_PRI;
            end
            default: w_state_nxt = ST_INIT;
         endcase
      end
   end

   // Mux select follows the active source; INIT and HOLD keep the last one used.
   always_comb begin
      w_sel_nxt = r_sel;
      if      (w_state_nxt == ST_PRI) w_sel_nxt = SEL_F5;
      else if (w_state_nxt == ST_SEC) w_sel_nxt = SEL_F64;
   end

   assign w_sel_change = (w_sel_nxt != r_sel);

   // State, select and status registers, all updated together so they stay consistent.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_sel       <= SEL_F5;
         r_src_valid <= 1'b0;
         r_holdover  <= 1'b0;
         r_pulse     <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_sel       <= w_sel_nxt;
         r_src_valid <= (w_state_nxt == ST_PRI) || (w_state_nxt == ST_SEC);
         r_holdover  <= (w_state_nxt == ST_HOLD);
         r_pulse     <= w_sel_change;
         if (w_sel_change && (r_cnt != CNT_SAT)) r_cnt <= r_cnt + 1'b1;
      end
   end

   // Revert timer: counts eligible cycles in SEC, clears on any break or transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rev_cnt <= '0;
      end else if (w_rev_en && (w_state_nxt == ST_SEC)) begin
         if (r_rev_cnt != REV_MAX) r_rev_cnt <= r_rev_cnt + 1'b1;
      end else begin
         r_rev_cnt <= '0;
      end
   end

   assign sel_f64      = r_sel;
   assign src_valid    = r_src_valid;
   assign holdover     = r_holdover;
   assign switch_pulse = r_pulse;
   assign switch_cnt   = r_cnt;
   assign state_o      = r_state;

endmodule

// File: tb/tb_ref_clk_supervisor.sv
// Self-checking bench for ref_clk_supervisor: directed scenarios followed by
// random flag/force/revert activity, compared cycle by cycle against a
// behavioural model built from sliding windows of raw samples.
module tb_ref_clk_supervisor;

   localparam int DEB = 4;
   localparam int REV = 8;
   localparam int CW  = 8;

   localparam int S_INIT = 0;
   localparam int S_PRI  = 1;
   localparam int S_SEC  = 2;
   localparam int S_HOLD = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          err_5, err_64, force_en, force_sel, revertive;
   logic          sel_f64, src_valid, holdover, switch_pulse;
   logic [CW-1:0] switch_cnt;
   logic [1:0]    state_o;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   ref_clk_supervisor #(.DEB_CYCLES(DEB), .REVERT_DLY(REV), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .err_5        (err_5),
      .err_64       (err_64),
      .force_en     (force_en),
      .force_sel    (force_sel),
      .revertive    (revertive),
      .sel_f64      (sel_f64),
      .src_valid    (src_valid),
      .holdover     (holdover),
      .switch_pulse (switch_pulse),
      .switch_cnt   (switch_cnt),
      .state_o      (state_o)
   );

   // ---------------- behavioural model ----------------
   bit m_h5[$];
   bit m_h64[$];
   bit m_bad5, m_bad64;
   int m_state, m_nxt, m_run, m_cnt;
   bit m_sel, m_new_sel, m_pulse, m_g5, m_g64, m_elig;

   // A filtered flag flips once the last DEB raw samples all disagree with it.
   function automatic bit window_flips(input bit q[$], input bit cur);
      if (q.size() < DEB) return 1'b0;
      foreach (q[i]) if (q[i] == cur) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_h5.delete(); m_h64.delete();
         m_bad5 = 1; m_bad64 = 1;
         m_state = S_INIT; m_run = 0; m_cnt = 0; m_sel = 0; m_pulse = 0;
      end else begin
         m_g5  = !m_bad5;
         m_g64 = !m_bad64;
         m_elig = (m_state == S_SEC) && m_g5 && revertive && !force_en;
         m_nxt = m_state;
         if (force_en) begin
            if (force_sel) m_nxt = m_g64 ? S_SEC : S_HOLD;
            else           m_nxt = m_g5  ? S_PRI : S_HOLD;
         end else if (m_state == S_INIT || m_state == S_HOLD) begin
            m_nxt = m_g5 ? S_PRI : (m_g64 ? S_SEC : m_state);
         end else if (m_state == S_PRI) begin
            if (!m_g5) m_nxt = m_g64 ? S_SEC : S_HOLD;
         end else begin
            if (!m_g64)                      m_nxt = m_g5 ? S_PRI : S_HOLD;
            else if (m_elig && m_run + 1 == REV) m_nxt = S_PRI;
         end
         // m_run = number of consecutive eligible cycles spent staying in SEC
         m_run = (m_elig && m_nxt == S_SEC) ? m_run + 1 : 0;
         m_new_sel = (m_nxt == S_PRI) ? 1'b0 : (m_nxt == S_SEC) ? 1'b1 : m_sel;
         m_pulse = (m_new_sel != m_sel);
         if (m_pulse) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
         m_sel = m_new_sel;
         m_state = m_nxt;
         m_h5.push_back(err_5);
         if (m_h5.size() > DEB) void'(m_h5.pop_front());
         m_h64.push_back(err_64);
         if (m_h64.size() > DEB) void'(m_h64.pop_front());
         if (window_flips(m_h5, m_bad5))   m_bad5  = ~m_bad5;
         if (window_flips(m_h64, m_bad64)) m_bad64 = ~m_bad64;
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got=%0d expected=%0d", tag, $time, got, exp);
      end
   endtask

   task automatic compare_model();
      check("state",  32'(state_o),      32'(m_state));
      check("sel",    32'(sel_f64),      32'(m_sel));
      check("valid",  32'(src_valid),    32'(m_state == S_PRI || m_state == S_SEC));
      check("hold",   32'(holdover),     32'(m_state == S_HOLD));
      check("pulse",  32'(switch_pulse), 32'(m_pulse));
      check("cnt",    32'(switch_cnt),   32'(m_cnt));
   endtask

   // One clock: inputs already set; sample outputs on the falling edge.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         compare_model();
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1; err_5 = 0; err_64 = 0; force_en = 0; force_sel = 0; revertive = 0;
      @(negedge clk);
      tick(2);
      check("rst_state", 32'(state_o), 0);
      check("rst_cnt",   32'(switch_cnt), 0);

      // 1: both flags clean -> good after DEB cycles, PRI one cycle later
      rst = 0;
      tick(DEB);
      check("t1_init", 32'(state_o), S_INIT);
      tick(1);
      check("t1_pri", 32'(state_o), S_PRI);
      check("t1_sel", 32'(sel_f64), 0);

      // 2: short glitch ignored, sustained loss switches to f64
      err_5 = 1; tick(DEB - 1);
      err_5 = 0; tick(6);
      check("t2_glitch", 32'(state_o), S_PRI);
      err_5 = 1; tick(DEB);
      check("t2_still_pri", 32'(state_o), S_PRI);
      tick(1);
      check("t2_sec", 32'(state_o), S_SEC);
      check("t2_pulse", 32'(switch_pulse), 1);
      check("t2_cnt", 32'(switch_cnt), 1);

      // 3: revertive return after filter + REV good cycles
      revertive = 1; err_5 = 0;
      tick(DEB + REV - 1);
      check("t3_not_yet", 32'(state_o), S_SEC);
      tick(1);
      check("t3_revert", 32'(state_o), S_PRI);
      check("t3_cnt", 32'(switch_cnt), 2);
      // non-revertive stays on f64
      revertive = 0; err_5 = 1; tick(DEB + 2);
      err_5 = 0; tick(40);
      check("t3_stay", 32'(state_o), S_SEC);
      revertive = 1; tick(REV + 1);

      // 4: both flags lost together -> HOLD, select unchanged, no pulse
      err_5 = 1; err_64 = 1; tick(DEB + 1);
      check("t4_hold", 32'(holdover), 1);
      check("t4_sel", 32'(sel_f64), 0);
      check("t4_nopulse", 32'(switch_pulse), 0);
      err_64 = 0; tick(DEB + 1);
      check("t4_sec", 32'(state_o), S_SEC);
      check("t4_pulse", 32'(switch_pulse), 1);

      // 5: force to a bad f64 holds even with f5 good
      err_5 = 0; err_64 = 1; force_en = 1; force_sel = 1; tick(10);
      check("t5_hold", 32'(state_o), S_HOLD);
      err_64 = 0; tick(DEB + 1);
      check("t5_sec", 32'(state_o), S_SEC);
      tick(2);
      force_en = 0; revertive = 1; tick(REV - 1);
      check("t5_wait", 32'(state_o), S_SEC);
      tick(1);
      check("t5_revert", 32'(state_o), S_PRI);

      // 6: reset mid-SEC, then saturate the switch counter
      force_en = 1; force_sel = 1; tick(2);
      rst = 1; tick(1);
      check("t6_rst_state", 32'(state_o), S_INIT);
      check("t6_rst_cnt", 32'(switch_cnt), 0);
      check("t6_rst_sel", 32'(sel_f64), 0);
      rst = 0; tick(DEB + 2);
      for (int i = 0; i < 300; i++) begin
         force_sel = ~force_sel;
         tick(1);
      end
      check("t6_sat", 32'(switch_cnt), 255);
      force_en = 0;

      // random activity against the model
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(399) == 0);
         if ($urandom_range(7) == 0)  err_5     = ~err_5;
         if ($urandom_range(7) == 0)  err_64    = ~err_64;
         if ($urandom_range(59) == 0) force_en  = ~force_en;
         if ($urandom_range(9) == 0)  force_sel = ~force_sel;
         if ($urandom_range(49) == 0) revertive = ~revertive;
         tick(1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
